lamp_debounce_ctrl: RTL

Sequential receiving end of the three-switch lamp interface. It takes the raw staircase switch levels S1/S2/S3, synchronizes and debounces each one, and drives lamp output F as the parity of the debounced switch states, so any accepted toggle of any switch flips the lamp. It also reports every accepted toggle as a one-cycle event carrying the switch identity and a running toggle count, for display and checking logic downstream.

---
 rtl/lamp_debounce_ctrl_if.sv | 33 +++
 rtl/lamp_debounce_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/lamp_debounce_ctrl_if.sv
// Three-switch lamp interface: raw switch levels in, lamp drive and toggle events out.
// The master drives the switches; the slave is the debouncing lamp controller.
interface lamp_debounce_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             S1;
    logic             S2;
    logic             S3;
    logic             F;
    logic             sw_evt;
    logic [1:0]       sw_id;
    logic [CNT_W-1:0] toggle_cnt;

    modport master (
        output S1,
        output S2,
        output S3,
        input  F,
        input  sw_evt,
        input  sw_id,
        input  toggle_cnt
    );

    modport slave (
        input  S1,
        input  S2,
        input  S3,
        output F,
        output sw_evt,
        output sw_id,
        output toggle_cnt
    );
endinterface

// File: rtl/lamp_debounce_ctrl.sv
// Synchronizes and debounces three staircase switches; the lamp is the parity of the
// debounced states, and every accepted change is reported as a one-cycle counted event.
module lamp_debounce_ctrl #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lamp_debounce_ctrl_if.slave  bus
);
    localparam logic [7:0] DbLast = 8'(DB_CYCLES - 1);

    logic [2:0]       raw;
    logic [2:0]       meta_q;
    logic [2:0]       sync_q;
    logic [2:0]       db_q;
    logic [2:0]       db_d;
    logic [2:0]       acc;
    logic [7:0]       cnt_q [3];
    logic [7:0]       cnt_d [3];
    logic             sw_evt_q;
    logic             sw_evt_d;
    logic [1:0]       sw_id_q;
    logic [1:0]       sw_id_d;
    logic [CNT_W-1:0] toggle_cnt_q;
    logic [CNT_W-1:0] toggle_cnt_d;

    assign raw = {bus.S3, bus.S2, bus.S1};

    // Per-switch run counter: a change is accepted only after DB_CYCLES mismatching cycles.
    always_comb begin
        db_d = db_q;
        acc  = '0;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DbLast) begin
                db_d[i]  = sync_q[i];
                cnt_d[i] = '0;
                acc[i]   = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    // Simultaneous acceptances report the lowest switch but count every one of them.
    always_comb begin
        sw_evt_d = |acc;
        if (acc[0]) begin
            sw_id_d = 2'd1;
        end else if (acc[1]) begin
            sw_id_d = 2'd2;
        end else if (acc[2]) begin
            sw_id_d = 2'd3;
        end else begin
            sw_id_d = 2'd0;
        end
        toggle_cnt_d = toggle_cnt_q + CNT_W'(acc[0]) + CNT_W'(acc[1]) + CNT_W'(acc[2]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q       <= '0;
            sync_q       <= '0;
            db_q         <= '0;
            sw_evt_q     <= 1'b0;
            sw_id_q      <= '0;
            toggle_cnt_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            meta_q       <= raw;
            sync_q       <= meta_q;
            db_q         <= db_d;
            sw_evt_q     <= sw_evt_d;
            sw_id_q      <= sw_id_d;
            toggle_cnt_q <= toggle_cnt_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.F          = ^db_q;
    assign bus.sw_evt     = sw_evt_q;
    assign bus.sw_id      = sw_id_q;
    assign bus.toggle_cnt = toggle_cnt_q;
endmodule
